// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_control_unit_pkg;

    // Sequencer states: normal flow, or EX occupied by a multi-cycle mul/div.
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hcu_state_e;

    // Architectural zero register; writes to it never create a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default width of the performance counters.
    localparam int DEFAULT_CNT_W = 32;

    // True when the load in EX produces a register the ID instruction reads.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return mem_read && (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // Clear wins over increment; the count sticks once it reaches all-ones.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// taken-redirect flushes, data-memory wait states and mul/div occupancy,
// plus saturating performance counters and a sticky mul/div watchdog.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int MD_TIMEOUT = 64            // must be >= 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             memRead_ex,
    input  logic             branch_taken_ex,
    input  logic             md_req_ex,
    input  logic             md_done,
    input  logic             dmem_stall,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_mem,
    output logic             md_start,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // Wide enough to hold MD_TIMEOUT-1.
    localparam int TO_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

    hcu_state_e      state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            armed_q, armed_d;   // cleared by a timeout until md_req_ex drops
    logic            md_error_q;
    logic            err_set;
    logic            lu_hit;

    assign lu_hit = load_use_hit(memRead_ex, rd_ex, rs1_id, rs2_id);

    // Priority decode of stalls/flushes plus next-state for the sequencer.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;
        md_start  = 1'b0;
        err_set   = 1'b0;
        state_d   = state_q;
        to_d      = to_q;
        armed_d   = armed_q;

        if (!rst) begin
            if (dmem_stall) begin
                // Whole pipe frozen; sequencer state and watchdog hold too.
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
            end else if (state_q == MD_WAIT) begin
                if (md_done) begin
                    // Result advances out of EX at this edge.
                    state_d = RUN;
                    to_d    = '0;
                end else begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    flush_mem = 1'b1;
                    if (to_q == TO_LAST) begin
                        // Watchdog expired: give up, flag it, and refuse to
                        // restart until the request line is seen low.
                        err_set = 1'b1;
                        state_d = RUN;
                        to_d    = '0;
                        armed_d = 1'b0;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
            end else if (md_req_ex && armed_q) begin
                md_start  = 1'b1;
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                flush_mem = 1'b1;
                state_d   = MD_WAIT;
                to_d      = '0;
            end else if (branch_taken_ex) begin
                // ID holds a wrong-path instruction, so any load-use match is moot.
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (lu_hit) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end

            if ((state_q == RUN) && !md_req_ex) begin
                armed_d = 1'b1;
            end
        end
    end

    // Sequencer state, watchdog counter, rearm flag and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            to_q       <= '0;
            armed_q    <= 1'b1;
            md_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            armed_q <= armed_d;
            if (err_set) begin
                md_error_q <= 1'b1;
            end
        end
    end

    assign md_error = md_error_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .clr_i   (rst),
        .inc_i   (stall_if),
        .count_o (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .clr_i   (rst),
        .inc_i   (flush_id),
        .count_o (flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit. u_dut uses narrow counters and a
// moderate watchdog; u_to shares the inputs and has a short watchdog.
module tb_hazard_control_unit;

    logic       clk;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       memRead_ex, branch_taken_ex, md_req_ex, md_done, dmem_stall;

    logic       a_sif, a_sid, a_sex, a_smem, a_fid, a_fex, a_fmem, a_mds, a_err;
    logic [2:0] a_stall_cnt, a_flush_cnt;
    logic       b_sif, b_sid, b_sex, b_smem, b_fid, b_fex, b_fmem, b_mds, b_err;
    logic [31:0] b_stall_cnt, b_flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_control_unit #(.CNT_W(3), .MD_TIMEOUT(8)) u_dut (
        .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
        .memRead_ex(memRead_ex), .branch_taken_ex(branch_taken_ex),
        .md_req_ex(md_req_ex), .md_done(md_done), .dmem_stall(dmem_stall),
        .stall_if(a_sif), .stall_id(a_sid), .stall_ex(a_sex), .stall_mem(a_smem),
        .flush_id(a_fid), .flush_ex(a_fex), .flush_mem(a_fmem), .md_start(a_mds),
        .md_error(a_err), .stall_cycles(a_stall_cnt), .flush_count(a_flush_cnt)
    );

    hazard_control_unit #(.CNT_W(32), .MD_TIMEOUT(4)) u_to (
        .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
        .memRead_ex(memRead_ex), .branch_taken_ex(branch_taken_ex),
        .md_req_ex(md_req_ex), .md_done(md_done), .dmem_stall(dmem_stall),
        .stall_if(b_sif), .stall_id(b_sid), .stall_ex(b_sex), .stall_mem(b_smem),
        .flush_id(b_fid), .flush_ex(b_fex), .flush_mem(b_fmem), .md_start(b_mds),
        .md_error(b_err), .stall_cycles(b_stall_cnt), .flush_count(b_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundles: {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, md_start}
    function automatic logic [7:0] outs_a();
        return {a_sif, a_sid, a_sex, a_smem, a_fid, a_fex, a_fmem, a_mds};
    endfunction
    function automatic logic [7:0] outs_b();
        return {b_sif, b_sid, b_sex, b_smem, b_fid, b_fex, b_fmem, b_mds};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
        memRead_ex = 1'b0; branch_taken_ex = 1'b0;
        md_req_ex = 1'b0; md_done = 1'b0; dmem_stall = 1'b0;
    endtask

    localparam logic [7:0] O_NONE  = 8'b0000_0000;
    localparam logic [7:0] O_LU    = 8'b1100_0100;
    localparam logic [7:0] O_BR    = 8'b0000_1100;
    localparam logic [7:0] O_MDST  = 8'b1110_0011;
    localparam logic [7:0] O_MDW   = 8'b1110_0010;
    localparam logic [7:0] O_DMEM  = 8'b1111_0000;

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "time limit");
    end

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();

        // Reset: every control output low even with all requests asserted.
        md_req_ex = 1'b1; dmem_stall = 1'b1; branch_taken_ex = 1'b1;
        memRead_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5;
        mid();
        chk("rst_outs_a", outs_a(), O_NONE);
        chk("rst_outs_b", outs_b(), O_NONE);
        chk("rst_stallcnt", a_stall_cnt, 0);
        chk("rst_flushcnt", a_flush_cnt, 0);
        chk("rst_err", a_err, 0);
        tick();
        idle();
        rst = 1'b0;
        tick();

        // Load-use on rs1, then the bubble cycle.
        memRead_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs2_id = 5'd0;
        mid(); chk("lu_rs1", outs_a(), O_LU);
        tick();
        idle();
        mid(); chk("lu_after", outs_a(), O_NONE);
        chk("lu_stallcnt", a_stall_cnt, 1);
        tick();

        // Load-use on rs2.
        memRead_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd3; rs2_id = 5'd7;
        mid(); chk("lu_rs2", outs_a(), O_LU);
        tick();

        // Load into x0 never stalls.
        memRead_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0; rs2_id = 5'd0;
        mid(); chk("lu_x0", outs_a(), O_NONE);
        chk("lu_stallcnt2", a_stall_cnt, 2);
        tick();

        // Non-matching load, and a matching non-load.
        memRead_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd6; rs2_id = 5'd4;
        mid(); chk("lu_nomatch", outs_a(), O_NONE);
        tick();
        memRead_ex = 1'b0; rd_ex = 5'd5; rs1_id = 5'd5;
        mid(); chk("lu_noload", outs_a(), O_NONE);
        tick();

        // Taken branch masks a simultaneous load-use.
        memRead_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; branch_taken_ex = 1'b1;
        mid(); chk("br_over_lu", outs_a(), O_BR);
        chk("br_flushcnt0", a_flush_cnt, 0);
        tick();
        idle();
        mid(); chk("br_after", outs_a(), O_NONE);
        chk("br_flushcnt1", a_flush_cnt, 1);
        chk("br_stallcnt", a_stall_cnt, 2);
        tick();

        // md_done while in RUN is ignored.
        md_done = 1'b1;
        mid(); chk("done_in_run", outs_a(), O_NONE);
        tick();
        idle();

        // Clear counters before the mul/div run.
        rst = 1'b1; tick(); rst = 1'b0;
        mid(); chk("clr_stallcnt", a_stall_cnt, 0);
        chk("clr_flushcnt", a_flush_cnt, 0);
        tick();

        // Mul/div: start cycle, five wait cycles, completion cycle.
        md_req_ex = 1'b1;
        mid(); chk("md_start", outs_a(), O_MDST);
        tick();
        for (int i = 0; i < 5; i++) begin
            mid(); chk("md_wait", outs_a(), O_MDW);
            tick();
        end
        md_done = 1'b1;
        mid(); chk("md_done", outs_a(), O_NONE);
        tick();
        idle();
        mid(); chk("md_after", outs_a(), O_NONE);
        chk("md_stallcnt", a_stall_cnt, 6);
        tick();

        // dmem_stall for 3 cycles inside MD_WAIT freezes the watchdog.
        md_req_ex = 1'b1;
        mid(); chk("dm_start", outs_a(), O_MDST);
        tick();
        for (int i = 0; i < 2; i++) begin
            mid(); chk("dm_wait_pre", outs_a(), O_MDW);
            tick();
        end
        dmem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid(); chk("dm_frozen", outs_a(), O_DMEM);
            tick();
        end
        dmem_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid(); chk("dm_wait_post", outs_a(), O_MDW);
            chk("dm_no_err", a_err, 0);
            tick();
        end
        md_done = 1'b1;
        mid(); chk("dm_done", outs_a(), O_NONE);
        tick();
        idle();
        mid(); chk("dm_err", a_err, 0);
        chk("sat_stallcnt", a_stall_cnt, 7);
        tick();

        // dmem_stall in RUN outranks a mul/div request: no md_start.
        dmem_stall = 1'b1; md_req_ex = 1'b1;
        mid(); chk("dm_over_md", outs_a(), O_DMEM);
        tick();
        idle();
        tick();

        // Watchdog on u_to (MD_TIMEOUT=4).
        rst = 1'b1; tick(); rst = 1'b0;
        mid(); chk("to_err_rst", b_err, 0);
        tick();
        md_req_ex = 1'b1;
        mid(); chk("to_start", outs_b(), O_MDST);
        tick();
        for (int i = 0; i < 4; i++) begin
            mid(); chk("to_wait", outs_b(), O_MDW);
            chk("to_err_pre", b_err, 0);
            tick();
        end
        mid(); chk("to_err_set", b_err, 1);
        chk("to_no_restart", outs_b(), O_NONE);
        chk("to_stallcnt", b_stall_cnt, 5);
        tick();
        mid(); chk("to_still_idle", outs_b(), O_NONE);
        tick();
        md_req_ex = 1'b0;
        mid(); chk("to_req_low", outs_b(), O_NONE);
        tick();
        md_req_ex = 1'b1;
        mid(); chk("to_rearmed", outs_b(), O_MDST);
        chk("to_err_sticky", b_err, 1);
        tick();

        // Reset while in MD_WAIT: no md_start in the reset cycle, RUN after.
        rst = 1'b1;
        mid(); chk("rst_mid_outs", outs_b(), O_NONE);
        tick();
        rst = 1'b0;
        mid(); chk("rst_mid_run", outs_b(), O_MDST);
        chk("rst_mid_err", b_err, 0);
        chk("rst_mid_cnt", b_stall_cnt, 0);
        tick();
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline; sits beside the forwarding logic and owns all pipeline-register enables and bubble inserts.
- Resolves load-use hazards, taken-branch/jump redirects, data-memory wait states and multi-cycle mul/div occupancy of EX, via a small FSM.
- Keeps saturating performance counters and a sticky mul/div watchdog error flag.

Parameters:
- CNT_W, 32, width of the stall and flush performance counters.
- MD_TIMEOUT, 64, maximum cycles in MD_WAIT before md_error is raised; must be at least 2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rs1_id  in  5  rs1 of the instruction in ID.
- rs2_id  in  5  rs2 of the instruction in ID.
- rd_ex  in  5  destination register of the instruction in EX.
- memRead_ex  in  1  instruction in EX is a load.
- branch_taken_ex  in  1  EX resolved a taken branch or jump; PC redirect this cycle.
- md_req_ex  in  1  instruction in EX is a mul/div op.
- md_done  in  1  mul/div unit result valid; one-cycle pulse.
- dmem_stall  in  1  data memory not ready this cycle.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID register.
- stall_ex  out  1  hold ID/EX register.
- stall_mem  out  1  hold EX/MEM and MEM/WB registers.
- flush_id  out  1  zero IF/ID register at the next edge.
- flush_ex  out  1  bubble into ID/EX at the next edge.
- flush_mem  out  1  bubble into EX/MEM at the next edge.
- md_start  out  1  one-cycle start pulse to the mul/div unit.
- md_error  out  1  sticky watchdog timeout.
- stall_cycles  out  CNT_W  cycles with stall_if high; saturating.
- flush_count  out  CNT_W  taken redirects (flush_id pulses); saturating.

Behaviour:
- Reset: state=RUN; timeout counter, md_error, stall_cycles and flush_count all 0. While rst is high, every stall, flush and md_start output is 0.
- FSM states: RUN and MD_WAIT. All outputs except the registered counters and md_error are combinational from state and inputs.
- Priority, evaluated each cycle:
  1. dmem_stall: all four stalls high; no flushes; md_start=0; state and timeout counter frozen.
  2. Mul/div:
     - In RUN with md_req_ex: md_start=1; stall_if, stall_id and stall_ex high; flush_mem=1; next state MD_WAIT.
     - In MD_WAIT without md_done: same stalls and flush_mem=1; md_start=0; timeout counter increments.
     - In MD_WAIT with md_done: no stall, no flush; the result advances at this edge; next state RUN; timeout counter cleared.
  3. branch_taken_ex: flush_id=1 and flush_ex=1; no stalls. Load-use is ignored because the ID instruction is wrong-path.
  4. Load-use: memRead_ex and rd_ex!=0 and (rd_ex==rs1_id or rd_ex==rs2_id) gives stall_if=1, stall_id=1, flush_ex=1 for exactly one cycle. A load into x0 never stalls.
  5. Otherwise all outputs 0.
- Latency: load-use adds exactly 1 bubble. A redirect costs 2 flushed slots. Mul/div holds EX from the md_start cycle through the md_done cycle inclusive.
- md_start is at most one pulse per operation; it is never reissued while in MD_WAIT.
- md_done in RUN is ignored.
- Timeout: when the MD_WAIT counter reaches MD_TIMEOUT-1 without md_done:
  - md_error is set (sticky until rst);
  - state returns to RUN with stalls released;
  - md_start is not reissued until md_req_ex deasserts and reasserts.
  This requires a one-bit rearm flag.
- Counters:
  - stall_cycles increments on every cycle with stall_if=1.
  - flush_count increments on every cycle with flush_id=1.
  - Both saturate at all-ones.
  - Neither increments during rst.
- Reset mid-operation: rst in MD_WAIT forces RUN on the next edge; no md_start is emitted in the reset cycle.

Decomposition:
- Shared package: the FSM state enum (RUN, MD_WAIT), the REG_ZERO constant, and the default CNT_W.
- One natural sub-module, sat_counter (parameterised width, inc, synchronous clr), instantiated twice for the performance counters.

Test Plan:
- Load-use: lw x5 in EX, ID reads rs1=5 -> single cycle with stall_if=stall_id=flush_ex=1, then all 0; repeat with rd_ex=0 -> no stall.
- Branch over load-use: branch_taken_ex=1 together with a load-use match -> flush_id=flush_ex=1, stall_if=0, flush_count 0->1.
- Mul/div: md_req_ex held, md_done pulsed 5 cycles after md_start -> md_start high 1 cycle only; stalls plus flush_mem for 6 cycles total; stall_cycles=6.
- dmem_stall asserted during MD_WAIT for 3 cycles -> all stalls high, timeout counter frozen, completion delayed by 3.
- Timeout with MD_TIMEOUT=4 and md_done never asserted -> md_error=1 after 4 MD_WAIT cycles; RUN; no md_start until md_req_ex toggles.
- Saturation with CNT_W=3: 10 stall cycles -> stall_cycles=7; rst -> all counters 0, md_error 0.
